// File: rtl/bcd_count2.sv
// bcd_count2: two-digit BCD up/down counter (00-99) stepped by an internal prescaler.
// Priority per edge is clr > valid load > step; tick/wrap/load_err are registered one-cycle pulses.
module bcd_count2 #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       wrap,
    output logic       load_err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    logic [PW-1:0] pre;
    logic          step;
    logic          load_ok;
    logic          step_wrap;
    logic [3:0]    tens_nx;
    logic [3:0]    ones_nx;
    assign step    = en && (pre == LAST);
    assign load_ok = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    // Next digits are formed directly in BCD so no non-BCD value ever reaches the registers.
    always_comb begin
        ones_nx   = up ? ((ones == 4'd9) ? 4'd0 : ones + 4'd1)
                       : ((ones == 4'd0) ? 4'd9 : ones - 4'd1);
        tens_nx   = tens;
        step_wrap = up ? (tens == 4'd9 && ones == 4'd9) : (tens == 4'd0 && ones == 4'd0);
        if (up && ones == 4'd9)
            tens_nx = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        if (!up && ones == 4'd0)
            tens_nx = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tens     <= 4'd0;
            ones     <= 4'd0;
            pre      <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            tens     <= 4'd0;
            ones     <= 4'd0;
            pre      <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load_ok) begin
            tens     <= load_val[7:4];
            ones     <= load_val[3:0];
            pre      <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // A rejected load falls through here, so counting proceeds as if load were low.
            load_err <= load;
            tick     <= step;
            wrap     <= step && step_wrap;
            if (step) begin
                tens <= tens_nx;
                ones <= ones_nx;
                pre  <= '0;
            end else if (en) begin
                pre <= pre + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bcd_count2.sv
// tb_bcd_count2: directed plus random stimulus on TICK_DIV=4 and TICK_DIV=1 instances sharing inputs,
// checked every cycle against an integer model of the count (0..99) and prescaler phase.
module tb_bcd_count2;
    logic       clock = 1'b0;
    logic       resetn, en, up, clr, load;
    logic [7:0] load_val;
    logic [3:0] tens4, ones4, tens1, ones1;
    logic       tick4, wrap4, err4, tick1, wrap1, err1;
    int         n_assert = 0;
    int         n_fail = 0;
    int         m_cnt[2];
    int         m_pre[2];
    bit         m_tk[2];
    bit         m_wr[2];
    bit         m_le[2];
    int         tdiv[2] = '{4, 1};
    int         n;

    bcd_count2 #(.TICK_DIV(4)) u4 (
        .clock(clock), .resetn(resetn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .tens(tens4), .ones(ones4), .tick(tick4), .wrap(wrap4),
        .load_err(err4)
    );
    bcd_count2 #(.TICK_DIV(1)) u1 (
        .clock(clock), .resetn(resetn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .tens(tens1), .ones(ones1), .tick(tick1), .wrap(wrap1),
        .load_err(err1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_pre[k] = 0;
            m_tk[k]  = 0;
            m_wr[k]  = 0;
            m_le[k]  = 0;
        end
    endtask

    task automatic model_edge(input int k);
        bit stp, ok;
        stp = en && (m_pre[k] == tdiv[k] - 1);
        ok  = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
        m_tk[k] = 0;
        m_wr[k] = 0;
        m_le[k] = 0;
        if (clr) begin
            m_cnt[k] = 0;
            m_pre[k] = 0;
        end else if (ok) begin
            m_cnt[k] = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
            m_pre[k] = 0;
        end else begin
            m_le[k] = load;
            if (stp) begin
                m_tk[k]  = 1;
                m_pre[k] = 0;
                m_wr[k]  = up ? (m_cnt[k] == 99) : (m_cnt[k] == 0);
                m_cnt[k] = (m_cnt[k] + (up ? 1 : 99)) % 100;
            end else if (en) begin
                m_pre[k]++;
            end
        end
    endtask

    task automatic check_all();
        chk("u4.tens", 32'(tens4), 32'(m_cnt[0] / 10));
        chk("u4.ones", 32'(ones4), 32'(m_cnt[0] % 10));
        chk("u4.tick", 32'(tick4), 32'(m_tk[0]));
        chk("u4.wrap", 32'(wrap4), 32'(m_wr[0]));
        chk("u4.load_err", 32'(err4), 32'(m_le[0]));
        chk("u1.tens", 32'(tens1), 32'(m_cnt[1] / 10));
        chk("u1.ones", 32'(ones1), 32'(m_cnt[1] % 10));
        chk("u1.tick", 32'(tick1), 32'(m_tk[1]));
        chk("u1.wrap", 32'(wrap1), 32'(m_wr[1]));
        chk("u1.load_err", 32'(err1), 32'(m_le[1]));
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!resetn) model_zero();
        else for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        check_all();
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!tick4 && cnt < 40);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cycle();
        load     = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
        model_zero();
        repeat (2) cycle();
        resetn = 1'b1;
        // 1: async reset mid-count at 37, then first tick four enabled cycles after release
        pulse_load(8'h37);
        en = 1'b1; up = 1'b1;
        repeat (2) cycle();
        chk("pre_reset_cnt", 32'({tens4, ones4}), 32'h37);
        #2 resetn = 1'b0;
        #1;
        chk("async_tens", 32'(tens4), 32'd0);
        chk("async_ones", 32'(ones4), 32'd0);
        model_zero();
        cycle();
        resetn = 1'b1;
        wait_tick(n);
        chk("first_tick_gap", 32'(n), 32'd4);
        chk("first_tick_cnt", 32'({tens4, ones4}), 32'h01);
        // 2: forty cycles from 00, then a three-cycle enable stall
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (40) cycle();
        chk("run40_cnt", 32'({tens4, ones4}), 32'h10);
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        wait_tick(n);
        chk("stall_gap", 32'(n + 3), 32'd7);
        // 3: wrap up through 99->00, then down through 00->99
        pulse_load(8'h98);
        chk("load98", 32'({tens4, ones4}), 32'h98);
        wait_tick(n);
        chk("up_99", 32'({tens4, ones4}), 32'h99);
        wait_tick(n);
        chk("up_wrap_cnt", 32'({tens4, ones4}), 32'h00);
        chk("up_wrap", 32'(wrap4), 32'd1);
        up = 1'b0;
        wait_tick(n);
        chk("dn_wrap_cnt", 32'({tens4, ones4}), 32'h99);
        chk("dn_wrap", 32'(wrap4), 32'd1);
        // 4: rejected load keeps the schedule; valid load on a step cycle swallows the step
        pulse_load(8'h3A);
        chk("bad_load_err", 32'(err4), 32'd1);
        chk("bad_load_cnt", 32'({tens4, ones4}), 32'h99);
        wait_tick(n);
        chk("bad_load_gap", 32'(n), 32'd3);
        chk("bad_load_step", 32'({tens4, ones4}), 32'h98);
        repeat (3) cycle();
        pulse_load(8'h42);
        chk("load_on_step_cnt", 32'({tens4, ones4}), 32'h42);
        chk("load_on_step_tick", 32'(tick4), 32'd0);
        up = 1'b1;
        wait_tick(n);
        chk("after_load_gap", 32'(n), 32'd4);
        chk("after_load_cnt", 32'({tens4, ones4}), 32'h43);
        // 5: clr beats load on a step cycle
        repeat (3) cycle();
        clr = 1'b1; load = 1'b1; load_val = 8'h55;
        cycle();
        clr = 1'b0; load = 1'b0;
        chk("clr_cnt", 32'({tens4, ones4}), 32'h00);
        chk("clr_tick", 32'(tick4), 32'd0);
        chk("clr_wrap", 32'(wrap4), 32'd0);
        chk("clr_err", 32'(err4), 32'd0);
        // 6: TICK_DIV=1 counts down every enabled cycle
        up = 1'b0;
        pulse_load(8'h10);
        chk("d1_load", 32'({tens1, ones1}), 32'h10);
        cycle();
        chk("d1_09", 32'({tens1, ones1, tick1}), 32'({8'h09, 1'b1}));
        cycle();
        chk("d1_08", 32'({tens1, ones1, tick1}), 32'({8'h08, 1'b1}));
        // random traffic against the model
        repeat (600) begin
            en       = ($urandom % 8) != 0;
            up       = 1'($urandom % 2);
            clr      = ($urandom % 40) == 0;
            load     = ($urandom % 8) == 0;
            load_val = ($urandom % 2) ? 8'($urandom)
                                      : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            resetn   = ($urandom % 100) != 0;
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_count2.md
Name: bcd_count2

Overview:
- Two-digit BCD up/down counter (00–99) driven by an internal prescaler tick.
- Sits directly upstream of the board's 7-segment decoders: `tens` feeds the HEX1 decoder and `ones` feeds the HEX0 decoder.
- Both digits are always valid BCD (0–9), so the decoders never show their blank/default pattern.
- Used for stopwatch and counter labs on the 50 MHz board.

Parameters:
- TICK_DIV, default 50000000: clock cycles per count step (1 Hz at 50 MHz). Legal range is ≥1. The prescaler width is derived internally (clog2).

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- resetn  input  1  asynchronous active-low reset
- en  input  1  count enable; gates the prescaler
- up  input  1  1 = count up, 0 = count down; sampled on the step cycle
- clr  input  1  synchronous clear to 00
- load  input  1  synchronous load strobe
- load_val  input  8  [7:4] tens, [3:0] ones, BCD
- tens  output  4  tens digit, BCD 0–9
- ones  output  4  ones digit, BCD 0–9
- tick  output  1  one-cycle pulse when a count step is applied
- wrap  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down)
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:

Reset
- resetn=0 forces immediately, regardless of clock: tens=0, ones=0, prescaler=0, tick=0, wrap=0, load_err=0.
- Release is synchronous to the next rising edge.

Prescaler
- Counts 0..TICK_DIV-1 while en=1 and holds while en=0.
- When it equals TICK_DIV-1 with en=1, that cycle is a step cycle; the prescaler returns to 0 on the next edge.
- TICK_DIV=1 makes every enabled cycle a step cycle.

Priority per edge: clr > valid load > step.
- clr=1:
  - tens/ones←0, prescaler←0.
  - tick=0, wrap=0 and load_err=0 on the next cycle.
  - load and step are ignored.
- load=1, valid (both nibbles ≤9):
  - tens/ones←load_val, prescaler←0.
  - A coincident step is discarded: no tick, no wrap.
- load=1, invalid (either nibble >9):
  - Load is ignored and load_err pulses 1 cycle.
  - Count, prescaler and any coincident step proceed exactly as if load=0.
- Step, up=1:
  - ones=9 → ones←0 and tens increments.
  - tens=9 and ones=9 → 00, wrap pulses.
- Step, up=0:
  - ones=0 → ones←9 and tens decrements.
  - 00 → 99, wrap pulses.

Timing
- tick, wrap and load_err are registered. Each is high for exactly the cycle following the triggering edge, i.e. concurrent with the new count value.
- Latency from the step-cycle edge to the updated digits is 0 cycles: the digits are registered on that edge.
- en=0 does not block clr or load.
- Toggling `up` between steps has no effect until the next step cycle.
- Asserting resetn mid-count discards the prescaler phase; after release the first step occurs TICK_DIV enabled cycles later.

Invariant
- tens≤9 and ones≤9 at all times.
- No intermediate non-BCD value is ever visible on an edge.

Test Plan (bench uses TICK_DIV=4):
1. resetn=0 mid-count at 37 → tens=0, ones=0 immediately, with no clock edge needed. Release with en=1, up=1 → first tick 4 cycles later with count 01.
2. en=1, up=1 from 00 for 40 cycles → count 09 then 10 at successive ticks, one tick pulse every 4 cycles. Stopping en for 3 cycles delays the next tick by exactly 3.
3. load 8'h98, up=1, run 2 steps → 99, then 00 with wrap=1 for one cycle. Switch up=0 and step → 99 with wrap=1.
4. load 8'h3A → load_err=1 for one cycle, count unchanged, ticks continue on schedule. Load 8'h42 on a step cycle → count 42, no tick that cycle, next step 4 cycles later gives 43.
5. clr and load (8'h55) asserted together on a step cycle → count 00, tick=0, wrap=0, load_err=0.
6. TICK_DIV=1 instance, up=0 from 10 → 09, 08 on consecutive cycles, tick high every cycle.
